// File: rtl/banki_pkg.sv
// Shared constants and types for the per-bank memory arbiters.
package banki_pkg;
   localparam int NUM_CPU       = 3;
   localparam int SIZE_BANKI    = 32;
   localparam int DATA_W        = 32;
   localparam int SHIRINA_BANKI = $clog2(SIZE_BANKI);
   localparam int PTR_W         = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

   typedef logic [NUM_CPU-1:0]       cpu_vec_t;
   typedef logic [SHIRINA_BANKI-1:0] bank_adr_t;
   typedef logic [DATA_W-1:0]        data_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod N.
module rr_pick
   import banki_pkg::*;
#(
   parameter int N  = NUM_CPU,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] win
);

   int   c;
   logic found;

   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      c     = 0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr) + i;
         if (c >= N) c = c - N;
         if (!found && req[c[PW-1:0]]) begin
            found          = 1'b1;
            gnt[c[PW-1:0]] = 1'b1;
            win            = c[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/bank_robin_arbiter.sv
// Per-bank round-robin arbiter: grants one CPU per cycle, registers the bank
// read strobe/address and steers the bank's read data back to the owner.
module bank_robin_arbiter
   import banki_pkg::*;
#(
   parameter int NUM_CPU       = banki_pkg::NUM_CPU,
   parameter int SIZE_BANKI    = banki_pkg::SIZE_BANKI,
   parameter int DATA_W        = banki_pkg::DATA_W,
   parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CPU-1:0]                     req_robin,
   input  logic [NUM_CPU-1:0][SHIRINA_BANKI-1:0]  ra_banki,
   output logic [NUM_CPU-1:0]                     gnt,
   output logic                                   bank_req,
   output logic [SHIRINA_BANKI-1:0]               bank_ra,
   input  logic [DATA_W-1:0]                      bank_rd,
   output logic [NUM_CPU-1:0]                     rd_valid,
   output logic [DATA_W-1:0]                      rd_data
);

   localparam int PW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      win;
   logic [NUM_CPU-1:0] own1;
   logic [NUM_CPU-1:0] own2;

   rr_pick #(.N(NUM_CPU), .PW(PW)) u_pick (
      .req (req_robin),
      .ptr (ptr),
      .gnt (gnt),
      .win (win)
   );

   // Ownership travels alongside the read so the data can be routed back
   // without any per-request bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         bank_req <= 1'b0;
         bank_ra  <= '0;
         own1     <= '0;
         own2     <= '0;
      end else begin
         if (|gnt) ptr <= (win == PW'(NUM_CPU-1)) ? '0 : win + PW'(1);
         bank_req <= |gnt;
         bank_ra  <= ra_banki[win];
         own1     <= gnt;
         own2     <= own1;
      end
   end

   assign rd_valid = own2;
   assign rd_data  = (|own2) ? bank_rd : '0;

endmodule

// File: tb/tb_bank_robin_arbiter.sv
// Bench for bank_robin_arbiter: directed vector table, async-reset sequence
// and a random soak, all checked through a response scoreboard.
module tb_bank_robin_arbiter;
   import banki_pkg::*;

   typedef logic [NUM_CPU-1:0][SHIRINA_BANKI-1:0] ra_t;
   typedef struct {
      bit       rst;
      bit       fix;
      ra_t      ra;
      cpu_vec_t req;
      cpu_vec_t exp;
   } vec_t;
   typedef struct {
      int       due;
      cpu_vec_t who;
      data_t    dat;
   } sb_t;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   cpu_vec_t  req_robin = '0;
   ra_t       ra_banki = '0;
   cpu_vec_t  gnt;
   logic      bank_req;
   bank_adr_t bank_ra;
   data_t     bank_rd = '0;
   cpu_vec_t  rd_valid;
   data_t     rd_data;

   bank_robin_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_robin (req_robin),
      .ra_banki  (ra_banki),
      .gnt       (gnt),
      .bank_req  (bank_req),
      .bank_ra   (bank_ra),
      .bank_rd   (bank_rd),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   int        n_total = 0;
   int        n_pass  = 0;
   int        cyc     = 0;
   sb_t       sb[$];
   vec_t      tbl[$];
   int        m_ptr;
   cpu_vec_t  m_prev_g;
   bank_adr_t m_prev_a;
   logic      bm_req;
   bank_adr_t bm_ra;
   int        waitc[NUM_CPU];

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic data_t mem(input bank_adr_t a);
      return 32'hA5A5_0000 | data_t'(a);
   endfunction

   function automatic data_t junk();
      return 32'hDEAD_0000 | data_t'(cyc[15:0]);
   endfunction

   function automatic cpu_vec_t model_pick(input cpu_vec_t r, input int p, output int idx);
      cpu_vec_t g = '0;
      idx = 0;
      for (int i = 0; i < NUM_CPU; i++) begin
         int c = (p + i) % NUM_CPU;
         if (g == '0 && r[c]) begin
            g[c] = 1'b1;
            idx  = c;
         end
      end
      return g;
   endfunction

   function automatic ra_t rand_ra();
      ra_t r;
      for (int i = 0; i < NUM_CPU; i++) r[i] = bank_adr_t'($urandom_range(0, SIZE_BANKI-1));
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      sb.delete();
      m_prev_g = '0;
      m_prev_a = '0;
      bm_req   = 1'b0;
      bm_ra    = '0;
      for (int i = 0; i < NUM_CPU; i++) waitc[i] = 0;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
   task automatic do_reset();
      rst_n     = 1'b0;
      req_robin = '0;
      bank_rd   = junk();
      #2;
      chk("rst_gnt", gnt, '0);
      chk("rst_bank_req", bank_req, 1'b0);
      chk("rst_bank_ra", bank_ra, '0);
      chk("rst_rd_valid", rd_valid, '0);
      chk("rst_rd_data", rd_data, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      cyc++;
   endtask

   task automatic cycle(input cpu_vec_t req, input bit fix, input ra_t ra,
                        input bit use_exp, input cpu_vec_t exp_g, input bit soak);
      cpu_vec_t mg, ev;
      data_t    ed;
      int       idx;
      sb_t      e;
      bank_rd   = bm_req ? mem(bm_ra) : junk();
      req_robin = req;
      ra_banki  = fix ? ra : rand_ra();
      #2;
      mg = model_pick(req, m_ptr, idx);
      chk("gnt", gnt, use_exp ? exp_g : mg);
      chk("gnt_onehot0", $onehot0(gnt), 1'b1);
      chk("bank_req", bank_req, |m_prev_g);
      if (|m_prev_g) chk("bank_ra", bank_ra, m_prev_a);
      ev = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e  = sb.pop_front();
         ev = e.who;
         ed = e.dat;
      end
      chk("rd_valid", rd_valid, ev);
      chk("rd_data", rd_data, ed);
      chk("rd_valid_onehot0", $onehot0(rd_valid), 1'b1);
      if (soak) begin
         for (int i = 0; i < NUM_CPU; i++) begin
            waitc[i] = (req[i] && !gnt[i]) ? waitc[i] + 1 : 0;
            chk("wait_bound", waitc[i] <= NUM_CPU-1, 1'b1);
         end
      end
      if (|mg) begin
         e.due = cyc + 2;
         e.who = mg;
         e.dat = mem(ra_banki[idx]);
         sb.push_back(e);
         m_ptr = (idx + 1) % NUM_CPU;
      end
      m_prev_g = mg;
      m_prev_a = ra_banki[idx];
      bm_req   = bank_req;
      bm_ra    = bank_ra;
      cyc++;
      @(posedge clk); #1;
   endtask

   function automatic vec_t mk(input bit rst, input cpu_vec_t req, input cpu_vec_t exp);
      vec_t v;
      v.rst = rst; v.fix = 1'b0; v.ra = '0; v.req = req; v.exp = exp;
      return v;
   endfunction

   initial begin
      vec_t v;
      cpu_vec_t r, prev_r, prev_g;
      model_reset();

      // single request, CPU1 at address 7
      v = mk(1, 3'b010, 3'b010); v.fix = 1'b1; v.ra = {5'd0, 5'd7, 5'd0}; tbl.push_back(v);
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b100, 3'b100));  // ptr was 2 -> CPU2 first
      tbl.push_back(mk(0, 3'b011, 3'b001));  // ptr wrapped to 0
      // all three continuously from reset, then idle gap after CPU2
      tbl.push_back(mk(1, 3'b111, 3'b001));
      tbl.push_back(mk(0, 3'b111, 3'b010));
      tbl.push_back(mk(0, 3'b111, 3'b100));
      tbl.push_back(mk(0, 3'b111, 3'b001));
      tbl.push_back(mk(0, 3'b111, 3'b010));
      tbl.push_back(mk(0, 3'b111, 3'b100));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b101, 3'b001));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      // wrap and skip: ptr=2 with 011 -> CPU0, then CPU1
      tbl.push_back(mk(1, 3'b010, 3'b010));
      tbl.push_back(mk(0, 3'b011, 3'b001));
      tbl.push_back(mk(0, 3'b011, 3'b010));
      tbl.push_back(mk(0, 3'b000, 3'b000));
      tbl.push_back(mk(0, 3'b000, 3'b000));

      @(posedge clk); #1;
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         cycle(tbl[i].req, tbl[i].fix, tbl[i].ra, 1'b1, tbl[i].exp, 1'b0);
      end

      // async reset with a CPU1 read in flight
      do_reset();
      cycle(3'b001, 1'b0, '0, 1'b1, 3'b001, 1'b0);
      cycle(3'b010, 1'b0, '0, 1'b1, 3'b010, 1'b0);
      req_robin = '0;
      bank_rd   = junk();
      chk("mid_bank_req_before", bank_req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_bank_req", bank_req, 1'b0);
      chk("mid_own1", dut.own1, '0);
      chk("mid_own2", dut.own2, '0);
      chk("mid_rd_valid", rd_valid, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      cyc++;
      for (int i = 0; i < 4; i++) cycle(3'b000, 1'b0, '0, 1'b1, 3'b000, 1'b0);
      cycle(3'b011, 1'b0, '0, 1'b1, 3'b001, 1'b0);
      cycle(3'b000, 1'b0, '0, 1'b1, 3'b000, 1'b0);
      cycle(3'b000, 1'b0, '0, 1'b1, 3'b000, 1'b0);

      // random soak; a requester holds its request until granted
      prev_r = '0;
      prev_g = '0;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < NUM_CPU; i++)
            r[i] = (prev_r[i] && !prev_g[i]) ? 1'b1 : ($urandom_range(0, 99) < 55);
         cycle(r, 1'b0, '0, 1'b0, '0, 1'b1);
         prev_r = r;
         prev_g = gnt;
      end
      for (int i = 0; i < 3; i++) cycle(3'b000, 1'b0, '0, 1'b0, '0, 1'b0);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bank_robin_arbiter.md
# bank_robin_arbiter

Per-bank round-robin arbiter placed directly downstream of the address-to-bank decoder. It collects that bank's request bit from every CPU decoder, together with each CPU's in-bank address, and grants one CPU per cycle in rotating priority. It drives the bank's single read port through a registered stage and routes the bank's 1-cycle-latency read data back to the winning CPU with a valid pulse. The design has one instance per bank.

## Interface
Parameters:
- NUM_CPU, 3, number of requesting CPUs.
- SIZE_BANKI, 32, words per bank.
- DATA_W, 32, read data width.
- SHIRINA_BANKI, $clog2(SIZE_BANKI), in-bank address width.

Ports:
- clk  in  1  clock; single clock domain. All state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_robin  in  NUM_CPU  bit i = CPU i requests this bank; held by the CPU until granted.
- ra_banki  in  NUM_CPU x SHIRINA_BANKI  in-bank address from each CPU decoder.
- gnt  out  NUM_CPU  one-hot grant (combinational, same cycle as the request).
- bank_req  out  1  registered read strobe to the bank.
- bank_ra  out  SHIRINA_BANKI  registered read address to the bank.
- bank_rd  in  DATA_W  bank read data, valid one cycle after bank_req.
- rd_valid  out  NUM_CPU  one-hot pulse that marks returned data for CPU i.
- rd_data  out  DATA_W  returned data, shared by all CPUs and qualified by rd_valid.

## Operation
- Priority pointer `ptr` (0..NUM_CPU-1) names the highest-priority CPU. Search order: ptr, ptr+1, …, wrapping mod NUM_CPU.
- gnt is the first set bit of req_robin in search order. If req_robin == 0, then gnt = 0.
- On any grant to CPU k, ptr <= (k+1) mod NUM_CPU. With no grant, ptr holds.
- Stage 1 (registered): bank_req <= |gnt; bank_ra <= ra_banki[k]; own1 <= gnt. Address bits are don't-care when bank_req = 0, but the implementation still loads them.
- Stage 2 (registered): own2 <= own1.
- Response: rd_valid = own2, and rd_data = bank_rd when |own2, else 0. The response path is combinational from the stage-2 register and the bank data.
- No back-pressure. The bank accepts one read every cycle, so throughput is one grant per cycle.
- A single requester is granted immediately, regardless of ptr.
- If a CPU drops its request before being granted, it is simply not considered. No state is kept per pending request.
- The wrap of ptr from NUM_CPU-1 goes to 0.
- Reset values: ptr=0 (CPU0 highest), bank_req=0, bank_ra=0, own1=0, own2=0. Therefore gnt=0 only if req_robin=0, rd_valid=0 and rd_data=0.
- Reset asserted mid-operation clears own1 and own2 immediately. In-flight reads never produce rd_valid after reset, including after rst_n deasserts.
- Invariants: gnt, own1, own2 and rd_valid are each zero or one-hot.

## Timing
- Cycle T: req_robin[k]=1 and gnt[k]=1 (combinational).
- Edge T→T+1: bank_req=1 and bank_ra=ra_banki[k] during T+1.
- Cycle T+2: bank_rd holds the data, and rd_valid[k]=1 with rd_data=bank_rd.
- Read latency from grant cycle to data cycle is 2 cycles.
- Back-to-back grants in T and T+1 give rd_valid in T+2 and T+3 to their respective owners, with no bubble.
- The CPU must deassert or change req_robin in the cycle after it sees gnt, or it will be granted again when its turn returns.

## Structure
- Shared package `banki_pkg`:
  - constants NUM_CPU, SIZE_BANKI, DATA_W;
  - derived SHIRINA_BANKI;
  - typedefs `cpu_vec_t` (logic [NUM_CPU-1:0]), `bank_adr_t` (logic [SHIRINA_BANKI-1:0]) and `data_t`.
- One combinational sub-module, `rr_pick`, with inputs req vector and ptr, and outputs one-hot gnt and winner index. It is reused by any other arbiter in the memory system.
- The top module holds ptr, the two pipeline stages and the response mux. Total RTL is about 150–200 lines.

## Test plan
- Reset, then single request: req_robin=3'b010, ra_banki[1]=5'd7 in cycle 1.
  - gnt=010 in cycle 1; bank_req=1 and bank_ra=7 in cycle 2.
  - bank_rd=32'hA5A5_0007 in cycle 3 gives rd_valid=010 and rd_data=A5A5_0007.
  - ptr becomes 2.
- All three CPUs requesting continuously for 6 cycles from reset: gnt sequence is 001, 010, 100, 001, 010, 100, and rd_valid repeats the same sequence shifted by 2 cycles.
- Idle gap: req_robin=0 for 3 cycles after a grant to CPU2.
  - bank_req=0 and rd_valid=0 in the corresponding cycles; ptr stays 0.
  - Next request 3'b101 is granted to CPU0.
- Wrap and skip: with ptr=2 and req_robin=3'b011, gnt=001 (CPU2 skipped, wraps to 0), then ptr=1.
- Async reset mid-flight: grant CPU1 in cycle T, then assert rst_n low between the edges of T+1 (asynchronous).
  - bank_req, own1 and own2 go 0 immediately.
  - After release, rd_valid stays 0 until a new request; ptr=0.
- Randomized soak of 10k cycles with a scoreboard:
  - every grant yields exactly one rd_valid to the same CPU 2 cycles later, with matching data;
  - gnt and rd_valid are always zero or one-hot;
  - no requester waits more than NUM_CPU-1 cycles while continuously requesting.
